// File: rtl/branch_predict_unit.sv
// Branch resolution unit with a 2-bit-counter BHT for fetch-time prediction.
// Optional event counters are built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [4:0]        ex_op,
  input  logic [DATA_W-1:0] ex_rs,
  input  logic [DATA_W-1:0] ex_rt,
  input  logic [31:0]       ex_pc,
  input  logic [15:0]       ex_imm,
  input  logic [25:0]       ex_j_addr,
  input  logic              ex_pred_taken,
  input  logic [31:0]       if_pc,
  output logic              if_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [31:0]       res_target,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);
  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_BGTZ = 5'b01011;
  localparam logic [4:0] OP_BGEZ = 5'b01100;
  localparam logic [4:0] OP_BEQ  = 5'b01101;
  localparam logic [4:0] OP_BLEZ = 5'b01110;
  localparam logic [4:0] OP_BLTZ = 5'b01111;
  localparam logic [4:0] OP_J    = 5'b10000;

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             is_branch;
  logic             is_cond;
  logic             taken;
  logic             accepted;
  logic             mispredict_next;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_target;
  logic [31:0]      j_target;
  logic [31:0]      target_next;
  logic             unused_bits;

  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_idx = if_pc[IDX_W+1:2];
  assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

  // Fetch read sees the pre-update counter even when EX writes the same entry.
  assign if_pred_taken = bht[if_idx][1];

  assign pc_plus4  = ex_pc + 32'd4;
  assign br_target = pc_plus4 + {{14{ex_imm[15]}}, ex_imm, 2'b00};
  assign j_target  = {pc_plus4[31:28], ex_j_addr, 2'b00};

  always_comb begin
    is_branch = 1'b1;
    is_cond   = 1'b1;
    taken     = 1'b0;
    case (ex_op)
      OP_BEQ:  taken = (ex_rs == ex_rt);
      OP_BNE:  taken = (ex_rs != ex_rt);
      OP_BGTZ: taken = ($signed(ex_rs) >  0);
      OP_BGEZ: taken = ($signed(ex_rs) >= 0);
      OP_BLEZ: taken = ($signed(ex_rs) <= 0);
      OP_BLTZ: taken = ($signed(ex_rs) <  0);
      OP_J: begin
        taken   = 1'b1;
        is_cond = 1'b0;
      end
      default: begin
        is_branch = 1'b0;
        is_cond   = 1'b0;
      end
    endcase
  end

  assign accepted        = ex_valid & ~ex_stall & ~res_mispredict & is_branch;
  assign mispredict_next = taken != ex_pred_taken;

  always_comb begin
    target_next = pc_plus4;
    if (taken) target_next = (ex_op == OP_J) ? j_target : br_target;
  end

  always_comb begin
    ctr_cur  = bht[ex_idx];
    ctr_next = ctr_cur;
    if (taken && ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    else if (!taken && ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (accepted && is_cond) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // Outside a stall the result drops back to idle, which also clears any squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      res_target     <= 32'd0;
    end else if (!ex_stall) begin
      res_valid      <= accepted;
      res_mispredict <= accepted & mispredict_next;
      if (accepted) begin
        res_taken  <= taken;
        res_target <= target_next;
      end
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= 32'd0;
      mispredict_cnt <= 32'd0;
    end else begin
      if (accepted && branch_cnt != 32'hFFFF_FFFF)
        branch_cnt <= branch_cnt + 32'd1;
      if (accepted && mispredict_next && mispredict_cnt != 32'hFFFF_FFFF)
        mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  assign stat_branches    = branch_cnt;
  assign stat_mispredicts = mispredict_cnt;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand compare width (PC fixed at 32 bits).
REQ-002 Parameter BHT_DEPTH, default 64, number of 2-bit counters; power of two, 4..1024; IDX_W = log2(BHT_DEPTH).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ex_valid  in  1  branch-stage instruction valid.
REQ-006 ex_stall  in  1  pipeline hold; freezes block state.
REQ-007 ex_op  in  5  opcode: bne 01010, bgtz 01011, bgez 01100, beq 01101, blez 01110, bltz 01111, j 10000; any other value is a non-branch.
REQ-008 ex_rs  in  DATA_W  first operand.
REQ-009 ex_rt  in  DATA_W  second operand.
REQ-010 ex_pc  in  32  PC of the branch-stage instruction.
REQ-011 ex_imm  in  16  signed word offset.
REQ-012 ex_j_addr  in  26  jump word index.
REQ-013 ex_pred_taken  in  1  prediction made at fetch for this instruction.
REQ-014 if_pc  in  32  fetch PC for lookup.
REQ-015 if_pred_taken  out  1  combinational prediction for if_pc.
REQ-016 res_valid, res_taken, res_mispredict  out  1 each  registered resolution.
REQ-017 res_target  out  32  registered redirect PC.
REQ-018 stat_branches, stat_mispredicts  out  32 each  event counters.

Function
REQ-019 Comparisons are signed over DATA_W: beq rs==rt; bne rs!=rt; bgtz rs>0; bgez rs>=0; blez rs<=0; bltz rs<0; j always taken.
REQ-020 Branch target = ex_pc+4+(sign_ext(ex_imm)<<2), mod 2^32 wrap; jump target = {(ex_pc+4)[31:28], ex_j_addr, 2'b00}.
REQ-021 res_target = target when taken, else ex_pc+4.
REQ-022 Latency: one cycle; inputs sampled at edge N appear on res_* after edge N.
REQ-023 Accepted = ex_valid & !ex_stall & !res_mispredict & branch opcode; res_valid=1 for one cycle per accepted instruction, else 0.
REQ-024 Squash: while res_mispredict=1 the current ex_valid is ignored (no result, no BHT update, no count).
REQ-025 res_mispredict = res_valid & (res_taken != sampled ex_pred_taken).
REQ-026 ex_stall=1: res_* hold previous values, BHT and counters unchanged, squash still pending.
REQ-027 BHT index = pc[IDX_W+1:2]; if_pred_taken = counter[if_pc index] bit 1.
REQ-028 Counter update on accepted conditional branch only (not j): taken -> +1 saturating at 11, not taken -> -1 saturating at 00.
REQ-029 Same-index fetch read and update in one cycle: read returns pre-update value; no bypass.
REQ-030 Non-branch opcode with ex_valid: res_valid=0, no state change.

Reset
REQ-031 rst_n low asynchronously: res_valid, res_taken, res_mispredict=0; res_target=0; all BHT counters=01; stat counters=0.
REQ-032 Reset mid-operation discards any pending result and squash; first accepted instruction after release behaves as from cold.

Configuration
REQ-033 Macro BPU_STATS_EN defined: stat_branches increments per accepted instruction, stat_mispredicts per res_mispredict cycle, both saturating at 0xFFFFFFFF.
REQ-034 BPU_STATS_EN undefined: counters not built; stat ports present and tied to 0.

Verification
REQ-035 Reset, ex_op=beq, rs=rt=5, pc=0x100, imm=0x0004, pred=0 -> next cycle res_valid=1, taken=1, target=0x114, mispredict=1; counter[0x40 index] 01->10.
REQ-036 bgtz rs=0xFFFFFFFF, pred=0 -> taken=0, target=pc+4, mispredict=0; counter saturates at 00 after two such updates.
REQ-037 j, pc=0xA0000000, j_addr=0x0000010 -> target=0xA0000040, taken=1; BHT unchanged.
REQ-038 Mispredict cycle with ex_valid=1 beq in EX -> that instruction squashed, res_valid=0 next cycle; ex_stall=1 for 3 cycles -> res_* held constant.
REQ-039 BPU_STATS_EN defined, 3 branches with 1 mispredict -> stat_branches=3, stat_mispredicts=1; undefined -> both 0.
